// File: rtl/line_pkg.sv
// line_pkg: shared types and default parameters for the line segment scheduler.
package line_pkg;
  localparam int DEF_NSEG = 8;
  localparam int DEF_CW   = 12;
  localparam int DEF_TMO  = 4096;
  typedef struct packed {
    logic [DEF_CW-1:0] x0;
    logic [DEF_CW-1:0] y0;
    logic [DEF_CW-1:0] x1;
    logic [DEF_CW-1:0] y1;
    logic              ena;
  } seg_t;
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, WAIT} sched_state_t;
endpackage

// File: rtl/seg_bank.sv
// seg_bank: shadow/active segment tables; software writes the shadow and a copy strobe loads the active bank.
module seg_bank import line_pkg::*; #(
  parameter int NSEG = DEF_NSEG,
  localparam int IW  = $clog2(NSEG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  seg_t          wr_seg_i,
  input  logic          copy_i,
  input  logic [IW-1:0] rd_idx_i,
  output seg_t          rd_seg_o
);
  seg_t sh_q  [NSEG];
  seg_t act_q [NSEG];
  // A write landing in the copy cycle bypasses into the active bank.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < NSEG; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSEG; i++) begin
        if (wr_en_i && wr_idx_i == IW'(i)) sh_q[i] <= wr_seg_i;
        if (copy_i) act_q[i] <= (wr_en_i && wr_idx_i == IW'(i)) ? wr_seg_i : sh_q[i];
      end
    end
  assign rd_seg_o = act_q[rd_idx_i];
endmodule

// File: rtl/line_scheduler.sv
// line_scheduler: per-frame sequencer issuing enabled table segments to the line drawer with a done/timeout handshake.
module line_scheduler import line_pkg::*; #(
  parameter int NSEG = DEF_NSEG,
  parameter int CW   = DEF_CW,
  parameter int TMO  = DEF_TMO,
  localparam int IW  = $clog2(NSEG),
  localparam int TW  = $clog2(TMO)
) (
  input  logic          vga_clk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [CW-1:0] wr_x0,
  input  logic [CW-1:0] wr_y0,
  input  logic [CW-1:0] wr_x1,
  input  logic [CW-1:0] wr_y1,
  input  logic          wr_ena,
  output logic [CW-1:0] seg_x0,
  output logic [CW-1:0] seg_y0,
  output logic [CW-1:0] seg_x1,
  output logic [CW-1:0] seg_y1,
  output logic          seg_start,
  input  logic          eng_done,
  output logic [IW-1:0] seg_idx,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun,
  output logic          timeout
);
  sched_state_t    state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [4*CW-1:0] coord_q, coord_d;
  logic            vs_q, busy_q, busy_d, fd_q, fd_d, ov_q, ov_d, to_q, to_d;
  logic            rise, copy, last, expire, adv;
  seg_t            wr_seg, rd_seg;

  assign wr_seg = {wr_x0, wr_y0, wr_x1, wr_y1, wr_ena};

  seg_bank #(.NSEG(NSEG)) u_bank (
    .clk_i    (vga_clk),
    .rst_ni   (rst_n),
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx),
    .wr_seg_i (wr_seg),
    .copy_i   (copy),
    .rd_idx_i (ptr_q),
    .rd_seg_o (rd_seg)
  );

  assign rise   = vsync && !vs_q;
  assign last   = ptr_q == IW'(NSEG-1);
  assign expire = cnt_q == TW'(TMO-1);
  assign adv    = state_q == WAIT && (eng_done || expire);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    coord_d = coord_q;
    busy_d  = busy_q;
    fd_d    = 1'b0;
    ov_d    = rise && busy_q;
    to_d    = to_q || (adv && !eng_done);
    copy    = 1'b0;
    // Counting spans ISSUE so expiry lands exactly TMO cycles after seg_start.
    cnt_d   = (state_q == ISSUE || state_q == WAIT) ? cnt_q + TW'(1) : '0;
    case (state_q)
      IDLE: if (rise) begin
        copy    = 1'b1;
        ptr_d   = '0;
        busy_d  = 1'b1;
        state_d = SCAN;
      end
      SCAN: if (rd_seg.ena) begin
        state_d = ISSUE;
        idx_d   = ptr_q;
        coord_d = {rd_seg.x0, rd_seg.y0, rd_seg.x1, rd_seg.y1};
      end else if (last) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        fd_d    = 1'b1;
      end else ptr_d = ptr_q + IW'(1);
      ISSUE: state_d = WAIT;
      WAIT: if (adv) begin
        state_d = last ? IDLE : SCAN;
        busy_d  = !last;
        fd_d    = last;
        ptr_d   = last ? ptr_q : ptr_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      coord_q <= '0;
      vs_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      ov_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      coord_q <= coord_d;
      vs_q    <= vsync;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
      ov_q    <= ov_d;
      to_q    <= to_d;
    end

  assign {seg_x0, seg_y0, seg_x1, seg_y1} = coord_q;
  assign seg_start  = state_q == ISSUE;
  assign seg_idx    = idx_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign overrun    = ov_q;
  assign timeout    = to_q;
endmodule

// File: tb/tb_line_scheduler.sv
// tb_line_scheduler: directed checks of frame copy, issue order, overrun, timeout and reset behaviour.
module tb_line_scheduler;
  localparam int NSEG = 8;
  localparam int CW   = 12;
  localparam int TMO  = 4096;

  logic          vga_clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, wr_en = 1'b0, wr_ena = 1'b0, eng_done = 1'b0;
  logic [2:0]    wr_idx = '0;
  logic [CW-1:0] wr_x0 = '0, wr_y0 = '0, wr_x1 = '0, wr_y1 = '0;
  logic [CW-1:0] seg_x0, seg_y0, seg_x1, seg_y1;
  logic [2:0]    seg_idx;
  logic          seg_start, busy, frame_done, overrun, timeout;
  int            total = 0, bad = 0, n_start = 0, n, m;

  line_scheduler dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .vsync(vsync), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_x0(wr_x0), .wr_y0(wr_y0), .wr_x1(wr_x1), .wr_y1(wr_y1), .wr_ena(wr_ena),
    .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
    .seg_start(seg_start), .eng_done(eng_done), .seg_idx(seg_idx), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .timeout(timeout)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) if (seg_start) n_start++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge vga_clk);
  endtask

  task automatic wr(input int i, input int x0, input int y0, input int x1, input int y1, input logic e);
    wr_en = 1'b1; wr_idx = 3'(i); wr_ena = e;
    wr_x0 = CW'(x0); wr_y0 = CW'(y0); wr_x1 = CW'(x1); wr_y1 = CW'(y1);
    tick;
    wr_en = 1'b0;
  endtask

  task automatic rise;
    vsync = 1'b1; tick; vsync = 1'b0;
  endtask

  task automatic done_pulse;
    eng_done = 1'b1; tick; eng_done = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; tick; tick; rst_n = 1'b1; tick;
  endtask

  // which: 0 seg_start, 1 frame_done, 2 timeout; cnt = max+1 when it never shows
  task automatic wait_for(input int which, input int max, output int cnt);
    cnt = 0;
    do begin
      tick;
      cnt++;
    end while (!(which == 0 ? seg_start : which == 1 ? frame_done : timeout) && cnt <= max);
  endtask

  initial begin
    tick;
    chk("rst_start", seg_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", seg_idx, 0);
    chk("rst_seg", {seg_x0, seg_y0, seg_x1, seg_y1}, 0);
    chk("rst_tmo", timeout, 0);
    rst_n = 1'b1; tick;

    wr(0, 2, 7, 9, 2, 1'b1);
    wr(3, 0, 0, 639, 479, 1'b1);
    rise;
    chk("t1_busy", busy, 1);
    chk("t1_nostart", seg_start, 0);
    tick;
    chk("t1_start0", seg_start, 1);
    chk("t1_idx0", seg_idx, 0);
    chk("t1_seg0", {seg_x0, seg_y0, seg_x1, seg_y1}, {12'd2, 12'd7, 12'd9, 12'd2});
    tick;
    chk("t1_pulse", seg_start, 0);
    done_pulse;
    wait_for(0, 20, n);
    chk("t1_gap", n, 3);
    chk("t1_idx3", seg_idx, 3);
    chk("t1_seg3", {seg_x0, seg_y0, seg_x1, seg_y1}, {12'd0, 12'd0, 12'd639, 12'd479});
    tick; done_pulse;
    wait_for(1, 20, n);
    chk("t1_fd", n, 4);
    chk("t1_busy_lo", busy, 0);
    tick;
    chk("t1_fd_pulse", frame_done, 0);

    do_reset;
    m = n_start;
    rise;
    chk("t2_busy", busy, 1);
    eng_done = 1'b1; tick; eng_done = 1'b0;
    wait_for(1, 40, n);
    chk("t2_fd", n, NSEG - 1);
    chk("t2_nostart", n_start - m, 0);
    chk("t2_busy_lo", busy, 0);

    do_reset;
    wr(0, 10, 20, 30, 40, 1'b1);
    m = n_start;
    rise;
    wr(1, 5, 5, 5, 5, 1'b1);
    chk("t3_f1_start", seg_start, 1);
    chk("t3_f1_idx", seg_idx, 0);
    tick; done_pulse;
    wait_for(1, 20, n);
    chk("t3_f1_fd", n, 7);
    chk("t3_f1_cnt", n_start - m, 1);
    m = n_start;
    vsync = 1'b1;
    wr(2, 1, 2, 3, 4, 1'b1);
    vsync = 1'b0;
    tick;
    chk("t3_f2_idx0", seg_idx, 0);
    tick; done_pulse;
    wait_for(0, 20, n);
    chk("t3_f2_gap1", n, 1);
    chk("t3_f2_idx1", seg_idx, 1);
    chk("t3_f2_seg1", {seg_x0, seg_y0, seg_x1, seg_y1}, {12'd5, 12'd5, 12'd5, 12'd5});
    tick; done_pulse;
    wait_for(0, 20, n);
    chk("t3_f2_gap2", n, 1);
    chk("t3_f2_seg2", {seg_x0, seg_y0, seg_x1, seg_y1}, {12'd1, 12'd2, 12'd3, 12'd4});
    tick; done_pulse;
    wait_for(1, 20, n);
    chk("t3_f2_fd", n, 5);
    chk("t3_f2_cnt", n_start - m, 3);

    do_reset;
    wr(0, 11, 12, 13, 14, 1'b1);
    wr(5, 100, 200, 300, 400, 1'b1);
    rise; tick; tick;
    vsync = 1'b1;
    wr(3, 7, 7, 7, 7, 1'b1);
    vsync = 1'b0;
    chk("t4_ov", overrun, 1);
    chk("t4_idx", seg_idx, 0);
    chk("t4_busy", busy, 1);
    tick;
    chk("t4_ov_pulse", overrun, 0);
    done_pulse;
    wait_for(0, 20, n);
    chk("t4_gap", n, 5);
    chk("t4_idx5", seg_idx, 5);
    tick; done_pulse;
    wait_for(1, 20, n);
    chk("t4_fd", n, 2);

    rise; tick;
    chk("t5_idx0", seg_idx, 0);
    wait_for(2, TMO + 100, n);
    chk("t5_tmo_time", n, TMO);
    wait_for(0, 20, n);
    chk("t5_gap", n, 3);
    chk("t5_idx3", seg_idx, 3);
    chk("t5_seg3", {seg_x0, seg_y0, seg_x1, seg_y1}, {12'd7, 12'd7, 12'd7, 12'd7});
    tick; done_pulse;
    wait_for(0, 20, n);
    chk("t5_gap5", n, 2);
    chk("t5_sticky", timeout, 1);

    tick;
    rst_n = 1'b0; #1;
    chk("t6_busy", busy, 0);
    chk("t6_start", seg_start, 0);
    chk("t6_idx", seg_idx, 0);
    chk("t6_seg", {seg_x0, seg_y0, seg_x1, seg_y1}, 0);
    chk("t6_tmo", timeout, 0);
    tick; rst_n = 1'b1; tick;
    m = n_start;
    rise;
    wait_for(1, 40, n);
    chk("t6_fd", n, NSEG);
    chk("t6_nostart", n_start - m, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
